// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider with per-channel runtime half-period updates applied on toggle edges.
// Optional feature: define CLOCK_DIVIDER_SYNC_EN to add a global phase-align input `sync`.
module clock_divider_multi #(
    parameter int unsigned CHANNELS           = 4,
    parameter int unsigned CHANNEL_BIT_WIDTH  = 2,
    parameter int unsigned DIV_HALF_BIT_WIDTH = 16,
    parameter int unsigned DEFAULT_DIV_HALF   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef CLOCK_DIVIDER_SYNC_EN
    input  logic                          sync,
`endif
    input  logic [CHANNELS-1:0]           ch_enable,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CHANNEL_BIT_WIDTH-1:0]  cfg_channel,
    input  logic [DIV_HALF_BIT_WIDTH-1:0] cfg_div_half,
    output logic [CHANNELS-1:0]           clk_div,
    output logic [CHANNELS-1:0]           clk_tick
);

    typedef logic [DIV_HALF_BIT_WIDTH-1:0] half_t;

    half_t               half_q [CHANNELS];
    half_t               half_d [CHANNELS];
    half_t               pend_q [CHANNELS];
    half_t               pend_d [CHANNELS];
    half_t               num_q  [CHANNELS];
    half_t               num_d  [CHANNELS];
    half_t               eff    [CHANNELS];
    logic [CHANNELS-1:0] flag_q;
    logic [CHANNELS-1:0] flag_d;
    logic [CHANNELS-1:0] div_q;
    logic [CHANNELS-1:0] div_d;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic [CHANNELS-1:0] cfg_hit;
    logic [CHANNELS-1:0] terminal;

    // Out-of-range channel indices stay ready so the write is accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(cfg_channel) == i) begin
                cfg_ready = ~flag_q[i];
            end
        end
    end

    always_comb begin
        cfg_hit  = '0;
        terminal = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            eff[i]      = (half_q[i] == '0) ? half_t'(1) : half_q[i];
            terminal[i] = (num_q[i] == eff[i] - half_t'(1));
            cfg_hit[i]  = cfg_valid && cfg_ready && (32'(cfg_channel) == i);
        end
    end

    always_comb begin
        half_d = half_q;
        pend_d = pend_q;
        num_d  = num_q;
        flag_d = flag_q;
        div_d  = div_q;
        tick_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef CLOCK_DIVIDER_SYNC_EN
            if (sync) begin
                num_d[i] = '0;
                div_d[i] = 1'b0;
                if (flag_q[i]) begin
                    half_d[i] = pend_q[i];
                    flag_d[i] = 1'b0;
                end
                if (cfg_hit[i]) begin
                    half_d[i] = cfg_div_half;
                end
            end else
`endif
            if (!ch_enable[i]) begin
                num_d[i] = '0;
                div_d[i] = 1'b0;
                if (flag_q[i]) begin
                    half_d[i] = pend_q[i];
                    flag_d[i] = 1'b0;
                end
                if (cfg_hit[i]) begin
                    half_d[i] = cfg_div_half;
                end
            end else begin
                if (terminal[i]) begin
                    div_d[i]  = ~div_q[i];
                    tick_d[i] = ~div_q[i];
                    num_d[i]  = '0;
                    if (flag_q[i]) begin
                        half_d[i] = pend_q[i];
                        flag_d[i] = 1'b0;
                    end
                end else begin
                    num_d[i] = num_q[i] + half_t'(1);
                end
                // A write landing on a toggle edge is only staged; it takes effect next toggle.
                if (cfg_hit[i]) begin
                    pend_d[i] = cfg_div_half;
                    flag_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                half_q[i] <= half_t'(DEFAULT_DIV_HALF);
                pend_q[i] <= '0;
                num_q[i]  <= '0;
            end
            flag_q <= '0;
            div_q  <= '0;
            tick_q <= '0;
        end else begin
            half_q <= half_d;
            pend_q <= pend_d;
            num_q  <= num_d;
            flag_q <= flag_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign clk_div  = div_q;
    assign clk_tick = tick_q;

    tick_within_high: assert property (@(posedge clk) disable iff (!reset_n)
        (clk_tick & ~clk_div) == '0);

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a per-cycle model queues expected outputs,
// plus directed timing checks against fixed constants.
module tb_clock_divider_multi;

    localparam int CH  = 4;
    localparam int CBW = 3;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [CH-1:0]  ch_enable;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CBW-1:0] cfg_channel;
    logic [DW-1:0]  cfg_div_half;
    logic [CH-1:0]  clk_div;
    logic [CH-1:0]  clk_tick;
    logic           sync;

    clock_divider_multi #(
        .CHANNELS           (CH),
        .CHANNEL_BIT_WIDTH  (CBW),
        .DIV_HALF_BIT_WIDTH (DW),
        .DEFAULT_DIV_HALF   (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
`ifdef CLOCK_DIVIDER_SYNC_EN
        .sync         (sync),
`endif
        .ch_enable    (ch_enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_channel  (cfg_channel),
        .cfg_div_half (cfg_div_half),
        .clk_div      (clk_div),
        .clk_tick     (clk_tick)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    logic [2*CH-1:0] exp_q[$];
    int              m_h   [CH];
    int              m_p   [CH];
    int              m_num [CH];
    bit              m_f   [CH];
    bit              m_div [CH];
    bit              m_tick[CH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_channel) >= CH) return 1'b1;
        return !m_f[cfg_channel];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_h[i] = 1; m_p[i] = 0; m_num[i] = 0;
            m_f[i] = 0; m_div[i] = 0; m_tick[i] = 0;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven; queue the expectation.
    task automatic model_advance();
        logic [2*CH-1:0] e;
        bit xfer_ok;
        int eff;
        bit hit;
        xfer_ok = cfg_valid && model_ready();
        for (int i = 0; i < CH; i++) begin
            eff = (m_h[i] == 0) ? 1 : m_h[i];
            hit = xfer_ok && (int'(cfg_channel) == i);
            if (!reset_n) begin
                m_h[i] = 1; m_p[i] = 0; m_num[i] = 0;
                m_f[i] = 0; m_div[i] = 0; m_tick[i] = 0;
            end
`ifdef CLOCK_DIVIDER_SYNC_EN
            else if (sync) begin
                m_num[i] = 0; m_div[i] = 0; m_tick[i] = 0;
                if (m_f[i]) begin m_h[i] = m_p[i]; m_f[i] = 0; end
                if (hit) m_h[i] = int'(cfg_div_half);
            end
`endif
            else if (!ch_enable[i]) begin
                m_num[i] = 0; m_div[i] = 0; m_tick[i] = 0;
                if (m_f[i]) begin m_h[i] = m_p[i]; m_f[i] = 0; end
                if (hit) m_h[i] = int'(cfg_div_half);
            end else begin
                if (m_num[i] == eff - 1) begin
                    m_div[i]  = !m_div[i];
                    m_tick[i] = m_div[i];
                    m_num[i]  = 0;
                    if (m_f[i]) begin m_h[i] = m_p[i]; m_f[i] = 0; end
                end else begin
                    m_num[i]++;
                    m_tick[i] = 0;
                end
                if (hit) begin m_p[i] = int'(cfg_div_half); m_f[i] = 1; end
            end
            e[i]      = m_div[i];
            e[CH + i] = m_tick[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [2*CH-1:0] e;
        #1;
        check_val("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        model_advance();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("clk_div", 32'(clk_div), 32'(e[CH-1:0]));
        check_val("clk_tick", 32'(clk_tick), 32'(e[2*CH-1:CH]));
    endtask

    task automatic cfg_write(input int ch, input int half);
        cfg_valid = 1'b1; cfg_channel = CBW'(ch); cfg_div_half = DW'(half);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int n_high;
        logic [14:0] pat;
        int first[3];

        reset_n = 1'b0; ch_enable = '0; cfg_valid = 1'b0;
        cfg_channel = '0; cfg_div_half = '0; sync = 1'b0;
        @(posedge clk); #1;
        model_reset();

        phase = "reset";
        step(); step();
        check_val("reset_div", 32'(clk_div), 0);
        reset_n = 1'b1;
        step();

        phase = "ch0_h1";
        ch_enable = 4'b0001;
        n = 0;
        repeat (8) begin step(); n += int'(clk_tick[0]); end
        check_val("ch0_ticks", n, 4);

        phase = "ch1_h3";
        cfg_write(1, 3);
        ch_enable[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); n++; if (clk_div[1]) break; end
        check_val("ch1_first_rise", n, 3);
        n = 0; n_high = 0;
        for (int k = 0; k < 20; k++) begin
            step(); n++; n_high += int'(clk_div[1]);
            if (clk_tick[1]) break;
        end
        check_val("ch1_period", n, 6);
        check_val("ch1_high", n_high - 1, 2);

        phase = "ch2_update";
        cfg_write(2, 2);
        ch_enable[2] = 1'b1;
        step(); step();
        check_val("ch2_rise", 32'(clk_div[2]), 1);
        cfg_write(2, 5);
        cfg_channel = 3'd2;
        #1 check_val("ch2_ready_low", 32'(cfg_ready), 0);
        check_val("ch2_old_high", 32'(clk_div[2]), 1);
        step();
        pat = '0;
        pat[0] = clk_div[2];
        for (int k = 1; k < 15; k++) begin step(); pat[k] = clk_div[2]; end
        check_val("ch2_pattern", 32'(pat), 32'h03E0);

        phase = "ch3_zero";
        cfg_write(3, 0);
        ch_enable[3] = 1'b1;
        n = 0;
        repeat (6) begin step(); n += int'(clk_tick[3]); end
        check_val("ch3_ticks", n, 3);
        cfg_valid = 1'b1; cfg_channel = 3'd4; cfg_div_half = 16'd9;
        #1 check_val("oor_ready", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        n = 0;
        repeat (6) begin step(); n += int'(clk_tick[3]); end
        check_val("ch3_ticks_after_oor", n, 3);

        phase = "reset_mid";
        cfg_write(2, 7);
        cfg_channel = 3'd2;
        #1 check_val("ch2_pending", 32'(cfg_ready), 0);
        step();
        reset_n = 1'b0;
        step();
        check_val("rst_div", 32'(clk_div), 0);
        check_val("rst_tick", 32'(clk_tick), 0);
        reset_n = 1'b1; ch_enable = '0;
        #1 check_val("rst_no_pending", 32'(cfg_ready), 1);
        step();
        ch_enable = 4'b0010;
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); n++; if (clk_div[1]) break; end
        check_val("ch1_default_rise", n, 1);

        phase = "random";
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) ch_enable = CH'($urandom);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_channel  = CBW'($urandom_range(0, 5));
            cfg_div_half = DW'($urandom_range(0, 4));
            step();
        end
        cfg_valid = 1'b0;

`ifdef CLOCK_DIVIDER_SYNC_EN
        phase = "sync";
        ch_enable = '0;
        step();
        cfg_write(0, 2); cfg_write(1, 3); cfg_write(2, 4);
        ch_enable = 4'b0111;
        repeat (7) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync_div", 32'(clk_div), 0);
        first = '{0, 0, 0};
        for (int k = 1; k <= 10; k++) begin
            step();
            for (int c = 0; c < 3; c++) if (clk_div[c] && first[c] == 0) first[c] = k;
        end
        check_val("sync_rise0", first[0], 2);
        check_val("sync_rise1", first[1], 3);
        check_val("sync_rise2", first[2], 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, giving the number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter CHANNEL_BIT_WIDTH, default 2, giving the width of the channel index.
REQ-003 SHALL have parameter DIV_HALF_BIT_WIDTH, default 16, giving the width of the half-period count.
REQ-004 SHALL have parameter DEFAULT_DIV_HALF, default 1, giving the half-period loaded into every channel at reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port ch_enable, input, CHANNELS bits: per-channel run enable.
REQ-008 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the configuration write can be accepted.
REQ-010 SHALL have port cfg_channel, input, CHANNEL_BIT_WIDTH bits: the target channel index.
REQ-011 SHALL have port cfg_div_half, input, DIV_HALF_BIT_WIDTH bits: the new half-period in clk cycles.
REQ-012 SHALL have port clk_div, output reg, CHANNELS bits: the divided clock per channel.
REQ-013 SHALL have port clk_tick, output reg, CHANNELS bits: a one-cycle pulse per channel coincident with each clk_div rise.

Function
REQ-014 Each channel SHALL hold an active half-period H, a pending half-period P, a pending flag F and a counter num.
REQ-015 Effective half-period SHALL be max(H,1); a written value of 0 behaves as 1 (divide-by-2).
REQ-016 While ch_enable[i]=1: num increments each cycle; when num==H-1, clk_div[i] inverts and num returns to 0, giving period 2*H cycles at 50% duty.
REQ-017 clk_tick[i] SHALL be 1 exactly in the cycle clk_div[i] first reads 1 after a 0->1 transition, and 0 otherwise.
REQ-018 With ch_enable[i] sampled 0: next cycle clk_div[i]=0, clk_tick[i]=0, num=0; the pending update, if any, is applied (H<=P, F<=0).
REQ-019 On enable from idle: the first clk_div[i] rise occurs H edges after the first edge that samples ch_enable[i]=1.
REQ-020 cfg_ready SHALL equal ~F[cfg_channel] combinationally; cfg_ready=1 when cfg_channel>=CHANNELS.
REQ-021 A transfer occurs when cfg_valid&cfg_ready are both 1 at an edge; a transfer to an out-of-range channel SHALL be dropped silently.
REQ-022 On a transfer to a disabled channel: H<=cfg_div_half directly, F stays 0.
REQ-023 On a transfer to an enabled channel: P<=cfg_div_half, F<=1; P is applied (H<=P, F<=0) at that channel's next toggle edge, with num restarting at 0, so no runt or glitch pulse occurs.
REQ-024 A transfer in the same cycle as a toggle SHALL be applied at the following toggle, not the current one.
REQ-025 Channels SHALL be fully independent; traffic on one channel never alters the timing of another.

Reset
REQ-026 While reset_n=0 at an edge: clk_div=0, clk_tick=0, num=0, H=DEFAULT_DIV_HALF, P=0 and F=0 for all channels.
REQ-027 Reset asserted mid-period SHALL abort the period; no pending update survives.

Configuration
REQ-028 Macro CLOCK_DIVIDER_SYNC_EN, when defined, SHALL add a 1-bit input port sync.
REQ-029 With CLOCK_DIVIDER_SYNC_EN defined, sync=1 at an edge SHALL give every channel num=0, clk_div=0, clk_tick=0, and apply pending updates, phase-aligning all channels.
REQ-030 With CLOCK_DIVIDER_SYNC_EN defined, reset_n has priority over sync.
REQ-031 Without CLOCK_DIVIDER_SYNC_EN, the sync port and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-032 Reset, then enable ch0 with H=1 -> clk_div[0] toggles every cycle; clk_tick[0] pulses every 2nd cycle.
REQ-033 Write ch1 H=3 while disabled, then enable -> first rise 3 edges after enable, period 6, duty 3/3.
REQ-034 Write ch2 H=5 while running at H=2 -> cfg_ready low until the next toggle; the old 2/2 half-cycle completes, then 5/5 with no short pulse.
REQ-035 Write cfg_div_half=0 to ch3 -> divide-by-2; cfg_channel=4 with CHANNELS=4 -> accepted, no channel changes.
REQ-036 Assert reset_n=0 mid-period with F=1 -> all outputs 0 next edge; after release, H=DEFAULT_DIV_HALF.
REQ-037 With CLOCK_DIVIDER_SYNC_EN, run channels at H=2/3/4 and pulse sync -> all clk_div 0, then rise together relative to sync at +2/+3/+4 edges.
